// File: rtl/au_pkg.sv
// Shared definitions for the calculator AU: opcodes, sequencer states and
// the bit positions of the {C,V,Z,N} flag vector.
package au_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_NEG = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int F_C = 3;
    localparam int F_V = 2;
    localparam int F_Z = 1;
    localparam int F_N = 0;

endpackage

// File: rtl/au_sequencer_if.sv
// Operand/opcode request and result/flags response handshakes of the AU
// sequencer. The master side issues operations and consumes results.
interface au_sequencer_if #(parameter int W = 8);

    logic           in_valid;
    logic           in_ready;
    logic [1:0]     op;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic [3:0]     flags;

    modport master (
        output in_valid, op, opa, opb, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, opa, opb, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/au_adder.sv
// W-bit ripple-carry add/subtract unit that sits beside the sequencer.
// Subtraction is a + ~b + 1; C is the raw carry out, V the signed overflow.
module au_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         add_subtract,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovr,
    output logic         zero,
    output logic         neg
);

    logic [W:0] c;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = add_subtract;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ (b[i] ^ add_subtract) ^ c[i];
            c[i+1] = (a[i] & (b[i] ^ add_subtract)) | (c[i] & (a[i] ^ (b[i] ^ add_subtract)));
        end
    end

    assign cout = c[W];
    assign ovr  = c[W] ^ c[W-1];
    assign zero = (s == '0);
    assign neg  = s[W-1];

endmodule

// File: rtl/au_sequencer.sv
// Control stage in front of the AU adder: one-cycle ADD/SUB/NEG and an
// eight-iteration unsigned shift-and-add multiply, with valid/ready on both sides.
module au_sequencer
    import au_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    au_sequencer_if.slave        bus,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_sub,
    input  logic [W-1:0]         add_s,
    input  logic                 add_cout,
    input  logic                 add_ovr,
    input  logic                 add_zero,
    input  logic                 add_neg
);

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2*W-1:0] result_q, result_d;
    logic [3:0]     flags_q, flags_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;
    logic [2*W-1:0] prod_nxt;

    // One multiply step: shift {carry, partial sum, multiplier} right by one.
    always_comb begin
        if (lo_q[0]) prod_nxt = {add_cout, add_s, lo_q[W-1:1]};
        else         prod_nxt = {1'b0, hi_q, lo_q[W-1:1]};
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state_q)
            S_EXEC: begin
                case (op_q)
                    OP_ADD:  begin add_a = a_q; add_b = b_q; add_sub = 1'b0; end
                    OP_SUB:  begin add_a = a_q; add_b = b_q; add_sub = 1'b1; end
                    OP_NEG:  begin add_a = '0;  add_b = b_q; add_sub = 1'b1; end
                    default: ;
                endcase
            end
            S_MUL: begin
                add_a = hi_q;
                add_b = a_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d       = op_e'(bus.op);
                    a_d        = bus.opa;
                    b_d        = bus.opb;
                    in_ready_d = 1'b0;
                    if (op_e'(bus.op) == OP_MUL) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = bus.opb;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                result_d       = {{W{1'b0}}, add_s};
                flags_d[F_C]   = add_cout;
                flags_d[F_V]   = add_ovr;
                flags_d[F_Z]   = add_zero;
                flags_d[F_N]   = add_neg;
                out_valid_d    = 1'b1;
                state_d        = S_DONE;
            end
            S_MUL: begin
                {hi_d, lo_d} = prod_nxt;
                cnt_d        = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_d     = prod_nxt;
                    flags_d      = '0;
                    flags_d[F_C] = |prod_nxt[2*W-1:W];
                    flags_d[F_Z] = (prod_nxt == '0);
                    out_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: these are plain registers, not a memory array, so all of them
    // take the asynchronous reset and an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_au_sequencer.sv
// Directed bench for au_sequencer wired to au_adder: arithmetic results,
// latencies, backpressure, back-to-back operations and asynchronous abort.
module tb_au_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] add_a, add_b, add_s;
    logic       add_sub, add_cout, add_ovr, add_zero, add_neg;
    int         n_checks;
    int         n_pass;
    int         lat;

    au_sequencer_if #(.W(8)) bus ();

    au_sequencer #(.W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sub  (add_sub),
        .add_s    (add_s),
        .add_cout (add_cout),
        .add_ovr  (add_ovr),
        .add_zero (add_zero),
        .add_neg  (add_neg)
    );

    au_adder #(.W(8)) adder (
        .a            (add_a),
        .b            (add_b),
        .add_subtract (add_sub),
        .s            (add_s),
        .cout         (add_cout),
        .ovr          (add_ovr),
        .zero         (add_zero),
        .neg          (add_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an operation for one edge, then scrambles the inputs.
    task automatic start_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.opa      = a;
        bus.opb      = b;
        check("in_ready_before_accept", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.op       = 2'b01;
        bus.opa      = 8'hA5;
        bus.opb      = 8'h5A;
    endtask

    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [15:0] exp_res, input logic [3:0] exp_fl);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_flags"}, bus.flags, exp_fl);
        check({tag, "_adder_idle_in_done"}, {add_a, add_b, add_sub}, 0);
    endtask

    task automatic finish_op(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_cleared"}, bus.out_valid, 0);
        check({tag, "_in_ready_restored"}, bus.in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.opa       = 8'h00;
        bus.opb       = 8'h00;
        bus.out_ready = 1'b0;
        #23;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_result", bus.result, 0);
        check("reset_flags", bus.flags, 0);
        rst_n = 1'b1;
        step();
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_adder_ports", {add_a, add_b, add_sub}, 0);

        // ADD 7F+01: signed overflow into a negative result.
        start_op(2'b00, 8'h7F, 8'h01);
        wait_done("add_7f_01", 2, 16'h0080, 4'b0101);
        finish_op("add_7f_01");

        start_op(2'b01, 8'h05, 8'h05);
        wait_done("sub_05_05", 2, 16'h0000, 4'b1010);
        finish_op("sub_05_05");

        // NEG ignores operand A.
        start_op(2'b11, 8'h33, 8'h01);
        check("neg_drive", {add_a, add_b, add_sub}, {8'h00, 8'h01, 1'b1});
        wait_done("neg_01", 2, 16'h00FF, 4'b0001);
        finish_op("neg_01");

        start_op(2'b10, 8'hFF, 8'hFF);
        check("mul_drive_first", {add_a, add_b, add_sub}, {8'h00, 8'hFF, 1'b0});
        wait_done("mul_ff_ff", 9, 16'hFE01, 4'b1000);
        finish_op("mul_ff_ff");

        start_op(2'b10, 8'h00, 8'h37);
        wait_done("mul_00_37", 9, 16'h0000, 4'b0010);
        finish_op("mul_00_37");

        // Back-to-back: ADD presented in the first IDLE cycle after a MUL.
        start_op(2'b10, 8'h0C, 8'h0D);
        wait_done("mul_0c_0d", 9, 16'h009C, 4'b0000);
        finish_op("mul_0c_0d");
        start_op(2'b00, 8'h80, 8'h80);
        wait_done("add_80_80", 2, 16'h0000, 4'b1110);
        finish_op("add_80_80");

        // Backpressure: DONE held for five cycles while requests are offered.
        start_op(2'b00, 8'h12, 8'h34);
        wait_done("add_12_34", 2, 16'h0046, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = 2'(i);
            bus.opa      = 8'(8'h11 * i);
            bus.opb      = 8'h99;
            step();
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_result", bus.result, 16'h0046);
            check("bp_flags", bus.flags, 4'b0000);
        end
        bus.in_valid = 1'b0;
        finish_op("bp_release");
        step();
        check("bp_no_ghost_op", {bus.in_ready, bus.out_valid}, 2'b10);

        // Abort a multiply at cnt=4 with an asynchronous reset between edges.
        start_op(2'b10, 8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_result", bus.result, 0);
        check("abort_flags", bus.flags, 0);
        check("abort_adder_ports", {add_a, add_b, add_sub}, 0);
        #1;
        rst_n = 1'b1;
        step();
        check("abort_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 10; i++) step();
        check("abort_no_output", bus.out_valid, 0);

        start_op(2'b00, 8'h01, 8'h02);
        wait_done("add_01_02", 2, 16'h0003, 4'b0000);
        finish_op("add_01_02");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/au_sequencer.md
Name: au_sequencer

Overview:
- Control stage that sits directly upstream of the 8-bit ripple-carry add/subtract unit in the calculator AU.
- Accepts an operand pair plus opcode through a valid/ready handshake.
- Drives the adder's A, B and add_subtract inputs and captures its sum and flags into registers.
- Iterates the adder over 8 cycles for unsigned shift-and-add multiply, then presents the 16-bit result and flags on a valid/ready output handshake.

Parameters:
- W, 8, operand width; must match the adder width. Only 8 is verified.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  sequencer can accept (high only in IDLE)
- op  input  2  00 ADD, 01 SUB, 10 MUL (unsigned), 11 NEG (0 - B)
- opa  input  W  operand A
- opb  input  W  operand B
- add_a  output  W  to adder A
- add_b  output  W  to adder B (unmodified; the adder applies the inversion)
- add_sub  output  1  to adder add_subtract
- add_s  input  W  adder sum
- add_cout  input  1  adder carry out
- add_ovr  input  1  adder overflow
- add_zero  input  1  adder zero
- add_neg  input  1  adder negative
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer takes result
- result  output  2W  result; upper byte 0 for ADD/SUB/NEG
- flags  output  4  {C,V,Z,N}

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
  - On reset, all state returns to IDLE; result=0, flags=0, out_valid=0, internal counters and operand registers =0.
  - Reset mid-operation aborts the operation with no output.
- States: IDLE, EXEC, MUL, DONE.
- in_ready = (state==IDLE). Accept on in_valid&&in_ready: latch opa, opb, op.
  - op 00/01/11 -> EXEC; op 10 -> MUL with cnt=0, hi=0, lo=opb.
- Adder drive is combinational from registered state:
  - IDLE/DONE: add_a=0, add_b=0, add_sub=0.
  - EXEC: ADD a,b,0; SUB a,b,1; NEG 0,b,1.
  - MUL: add_a=hi, add_b=latched opa, add_sub=0.
- EXEC (1 cycle): on the next edge, result={0,add_s}, flags={add_cout,add_ovr,add_zero,add_neg}, state->DONE.
  - Latency from accept edge to out_valid: 2 edges.
- MUL (8 cycles):
  - Each edge: if lo[0], {hi,lo} <= {add_cout,add_s,lo}>>1; else {hi,lo} <= {1'b0,hi,lo}>>1; cnt++.
  - On the edge where cnt==7: result=final {hi,lo}, state->DONE.
  - Flags: C=|product[15:8], V=0, Z=(product==0), N=0.
  - Latency from accept edge: 9 edges.
- DONE: out_valid=1; result and flags held stable while out_ready=0.
  - out_valid&&out_ready -> IDLE, out_valid=0 on that edge.
  - result and flags keep their value until the next capture.
- No overlap: a new operation is accepted only in IDLE, i.e. the cycle after the handshake completes at the earliest. in_valid outside IDLE is ignored.
- Opcode and operand changes on the inputs after acceptance have no effect.

Decomposition:
- Shared package au_pkg: opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_NEG), state enum, flag bit indices (F_C=3, F_V=2, F_Z=1, F_N=0).
- No sub-module inside au_sequencer. The adder is instantiated beside it in the AU top and connected through the add_* ports. The bench instantiates both.

Test Plan:
- ADD 0x7F+0x01 -> result 0x0080, flags C0 V1 Z0 N1, out_valid exactly 2 edges after accept.
- SUB 0x05-0x05 -> result 0x0000, flags C1 V0 Z1 N0; NEG opb=0x01 -> result 0x00FF, flags C0 V0 Z0 N1.
- MUL 0xFF*0xFF -> result 0xFE01, flags C1 V0 Z0 N0, out_valid 9 edges after accept; MUL 0x00*0x37 -> 0x0000, Z=1.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> result/flags stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
- Back-to-back: ADD accepted the cycle after a MUL handshake completes -> correct independent results; add_* ports are 0 in IDLE/DONE.
- Assert rst_n low mid-MUL (cnt=4), asynchronously between edges -> immediate out_valid=0, result=0, flags=0, in_ready=1 after release; a following ADD 0x01+0x02 -> 0x0003.
